// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states, queue entry, reset PC
// and PC increment helper.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Sequential next PC, 32-bit modulo.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with push, pop and flush; head is read combinationally.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (32'(count) == DEPTH);
  assign do_pop  = pop & ~empty & ~flush;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; the consumer qualifies the head with count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, held single-outstanding cache request,
// response queue to decode, redirect flush. Optional counters under FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_ren,
  output logic [31:0] o_addr,
  input  logic        i_rvd,
  input  logic [31:0] i_inst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_perf_fetch,
  output logic [31:0] o_perf_drop
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e state;
  fetch_state_e state_n;

  logic [31:0]       pc;
  logic [31:0]       pc_n;
  logic [31:0]       addr_n;
  logic              ren_n;
  logic              push;
  logic              flush;
  logic              pop;
  logic [CW-1:0]     count;
  logic              outstanding;
  logic              issue_ok;
  logic              issue_b2b;
  logic [31:0]       target;
  logic [31:0]       addr_inc;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [ENTRY_W-1:0] head_bits;

  assign target      = i_redirect_pc & ~32'h3;
  assign addr_inc    = pc_inc(o_addr);
  assign outstanding = (state != IDLE);
  assign issue_ok    = (32'(count) + 32'(outstanding)) < DEPTH;
  // Back-to-back issue must leave room for the response being pushed this cycle.
  assign issue_b2b   = (32'(count) + 32'd1) < DEPTH;

  // State and request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      o_ren  <= 1'b0;
      o_addr <= RESET_PC;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      o_ren  <= ren_n;
      o_addr <= addr_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!i_redirect && issue_ok) state_n = WAIT;
      end
      WAIT: begin
        if (i_rvd && !i_redirect && !issue_b2b) state_n = IDLE;
        else if (!i_rvd && i_redirect)          state_n = DRAIN;
      end
      DRAIN: begin
        if (i_rvd) state_n = WAIT;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request, PC and queue control.
  always_comb begin
    pc_n   = pc;
    addr_n = o_addr;
    ren_n  = o_ren;
    push   = 1'b0;
    flush  = 1'b0;
    case (state)
      IDLE: begin
        if (i_redirect) begin
          flush = 1'b1;
          pc_n  = target;
        end else if (issue_ok) begin
          ren_n  = 1'b1;
          addr_n = pc;
        end
      end
      WAIT: begin
        if (i_rvd && i_redirect) begin
          // Response belongs to the squashed path; reissue at the target at once.
          flush  = 1'b1;
          pc_n   = target;
          addr_n = target;
          ren_n  = 1'b1;
        end else if (i_rvd) begin
          push = 1'b1;
          pc_n = addr_inc;
          if (issue_b2b) begin
            addr_n = addr_inc;
            ren_n  = 1'b1;
          end else begin
            ren_n = 1'b0;
          end
        end else if (i_redirect) begin
          flush = 1'b1;
          pc_n  = target;
          ren_n = 1'b0;
        end
      end
      DRAIN: begin
        if (i_redirect) begin
          flush = 1'b1;
          pc_n  = target;
        end
        if (i_rvd) begin
          ren_n  = 1'b1;
          addr_n = i_redirect ? target : pc;
        end
      end
      default: begin
        ren_n = 1'b0;
      end
    endcase
  end

  assign push_entry = '{pc: o_addr, inst: i_inst};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head_bits),
    .count (count)
  );

  assign head    = fetch_entry_t'(head_bits);
  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;
  assign o_pc    = o_valid ? head.pc   : 32'h0;
  assign o_inst  = o_valid ? head.inst : 32'h0;

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = i_rvd & (((state == WAIT) & i_redirect) | (state == DRAIN));

  // Kept pushes and discarded responses, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_perf_fetch <= 32'h0;
      o_perf_drop  <= 32'h0;
    end else begin
      if (push) o_perf_fetch <= o_perf_fetch + 32'd1;
      if (drop) o_perf_drop  <= o_perf_drop + 32'd1;
    end
  end
`else
  assign o_perf_fetch = 32'h0;
  assign o_perf_drop  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus latency and IDLE-redirect
// sequences. Expected values are hand computed for RESET_PC=0x100, DEPTH=4.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        o_ren;
  logic [31:0] o_addr;
  logic        i_rvd;
  logic [31:0] i_inst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_perf_fetch;
  logic [31:0] o_perf_drop;

  int checks;
  int failures;

`ifdef FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_ren         (o_ren),
    .o_addr        (o_addr),
    .i_rvd         (i_rvd),
    .i_inst        (i_inst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_perf_fetch  (o_perf_fetch),
    .o_perf_drop   (o_perf_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rvd;
    logic [31:0] inst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        ren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insto;
    int          pf;
    int          pd;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] in,
                              input logic rd, input logic [31:0] rp, input logic rdy,
                              input logic en, input logic [31:0] ad, input logic va,
                              input logic [31:0] p, input logic [31:0] io,
                              input int pf, input int pd);
    vec_t v;
    v.rst_n = r;  v.rvd = rv;  v.inst = in;  v.redir = rd;  v.rpc = rp;  v.ready = rdy;
    v.ren = en;   v.addr = ad; v.valid = va; v.pc = p;      v.insto = io;
    v.pf = pf;    v.pd = pd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_rvd = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int          busy;
    int          cnt;
    int          nacc;
    int          nrvd;
    logic        rvd_now;
    logic [31:0] req_addr;
    logic [31:0] rvd_addr;
    logic [31:0] exp_addr [3];

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i_rvd = 1'b0;
    i_inst = 32'h0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_ready = 1'b0;

    //        rst rvd inst          rdr rpc           rdy  ren addr          vld pc            inst         pf pd
    vt[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h100,      0, 32'h0,        32'h0,        0, 0);
    vt[1]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h100,      0, 32'h0,        32'h0,        0, 0);
    vt[2]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h100,      0, 32'h0,        32'h0,        0, 0);
    vt[3]  = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h100,      0, 32'h0,        32'h0,        0, 0);
    vt[4]  = mk(1, 1, 32'hAAAA0000, 0, 32'h0,        1,   1, 32'h104,      1, 32'h100,      32'hAAAA0000, 1, 0);
    vt[5]  = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h104,      0, 32'h0,        32'h0,        1, 0);
    vt[6]  = mk(1, 1, 32'hAAAA0001, 0, 32'h0,        0,   1, 32'h108,      1, 32'h104,      32'hAAAA0001, 2, 0);
    vt[7]  = mk(1, 1, 32'hAAAA0002, 0, 32'h0,        0,   1, 32'h10C,      1, 32'h104,      32'hAAAA0001, 3, 0);
    vt[8]  = mk(1, 1, 32'hAAAA0003, 0, 32'h0,        0,   1, 32'h110,      1, 32'h104,      32'hAAAA0001, 4, 0);
    vt[9]  = mk(1, 1, 32'hAAAA0004, 0, 32'h0,        0,   0, 32'h110,      1, 32'h104,      32'hAAAA0001, 5, 0);
    vt[10] = mk(1, 0, 32'h0,        0, 32'h0,        0,   0, 32'h110,      1, 32'h104,      32'hAAAA0001, 5, 0);
    vt[11] = mk(1, 0, 32'h0,        0, 32'h0,        1,   0, 32'h110,      1, 32'h108,      32'hAAAA0002, 5, 0);
    vt[12] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h114,      1, 32'h108,      32'hAAAA0002, 5, 0);
    vt[13] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h114,      1, 32'h108,      32'hAAAA0002, 5, 0);
    vt[14] = mk(1, 0, 32'h0,        1, 32'h203,      0,   0, 32'h114,      0, 32'h0,        32'h0,        5, 0);
    vt[15] = mk(1, 0, 32'h0,        1, 32'h300,      0,   0, 32'h114,      0, 32'h0,        32'h0,        5, 0);
    vt[16] = mk(1, 0, 32'h0,        1, 32'h402,      0,   0, 32'h114,      0, 32'h0,        32'h0,        5, 0);
    vt[17] = mk(1, 1, 32'hDEADDEAD, 0, 32'h0,        0,   1, 32'h400,      0, 32'h0,        32'h0,        5, 1);
    vt[18] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h400,      0, 32'h0,        32'h0,        5, 1);
    vt[19] = mk(1, 1, 32'hBBBB0000, 1, 32'h500,      1,   1, 32'h500,      0, 32'h0,        32'h0,        5, 2);
    vt[20] = mk(1, 1, 32'hBBBB0001, 0, 32'h0,        1,   1, 32'h504,      1, 32'h500,      32'hBBBB0001, 6, 2);
    vt[21] = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h504,      0, 32'h0,        32'h0,        6, 2);
    vt[22] = mk(1, 0, 32'h0,        1, 32'hFFFFFFFF, 0,   0, 32'h504,      0, 32'h0,        32'h0,        6, 2);
    vt[23] = mk(1, 1, 32'hDEADDEAD, 0, 32'h0,        0,   1, 32'hFFFFFFFC, 0, 32'h0,        32'h0,        6, 3);
    vt[24] = mk(1, 1, 32'hCCCC0000, 0, 32'h0,        0,   1, 32'h0,        1, 32'hFFFFFFFC, 32'hCCCC0000, 7, 3);
    vt[25] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0,        1, 32'hFFFFFFFC, 32'hCCCC0000, 7, 3);
    vt[26] = mk(0, 1, 32'hCCCC0001, 0, 32'h0,        0,   0, 32'h100,      0, 32'h0,        32'h0,        0, 0);
    vt[27] = mk(1, 0, 32'h0,        0, 32'h0,        0,   1, 32'h100,      0, 32'h0,        32'h0,        0, 0);

    // One vector per cycle: drive, clock, then compare the post-edge outputs.
    for (int i = 0; i < NV; i++) begin
      rst_n         = vt[i].rst_n;
      i_rvd         = vt[i].rvd;
      i_inst        = vt[i].inst;
      i_redirect    = vt[i].redir;
      i_redirect_pc = vt[i].rpc;
      i_ready       = vt[i].ready;
      @(posedge clk); #1;
      check($sformatf("v%0d ren", i),   32'(o_ren),   32'(vt[i].ren));
      check($sformatf("v%0d addr", i),  o_addr,       vt[i].addr);
      check($sformatf("v%0d valid", i), 32'(o_valid), 32'(vt[i].valid));
      check($sformatf("v%0d pc", i),    o_pc,         vt[i].pc);
      check($sformatf("v%0d inst", i),  o_inst,       vt[i].insto);
      check($sformatf("v%0d pfetch", i), o_perf_fetch, PERF_EN ? 32'(vt[i].pf) : 32'h0);
      check($sformatf("v%0d pdrop", i),  o_perf_drop,  PERF_EN ? 32'(vt[i].pd) : 32'h0);
    end

    // Latency-5 cache from reset release: back-to-back 0x100, 0x104, 0x108.
    do_reset();
    i_ready = 1'b1;
    exp_addr[0] = 32'h100;
    exp_addr[1] = 32'h104;
    exp_addr[2] = 32'h108;
    busy = 0;
    cnt = 0;
    nacc = 0;
    nrvd = 0;
    req_addr = 32'h0;
    rvd_addr = 32'h0;
    for (int c = 0; c < 60 && nrvd < 3; c++) begin
      i_rvd = 1'b0;
      if (busy != 0) begin
        cnt--;
        if (cnt == 0) begin
          i_rvd = 1'b1;
          i_inst = 32'hC000_0000 ^ req_addr;
          rvd_addr = req_addr;
          busy = 0;
        end
      end else if (o_ren) begin
        busy = 1;
        cnt = 5;
        req_addr = o_addr;
        if (nacc < 3) check($sformatf("lat5 req%0d addr", nacc), o_addr, exp_addr[nacc]);
        nacc++;
      end
      rvd_now = i_rvd;
      @(posedge clk); #1;
      if (rvd_now) begin
        check($sformatf("lat5 rsp%0d valid", nrvd), 32'(o_valid), 32'h1);
        check($sformatf("lat5 rsp%0d pc", nrvd), o_pc, exp_addr[nrvd]);
        check($sformatf("lat5 rsp%0d inst", nrvd), o_inst, 32'hC000_0000 ^ exp_addr[nrvd]);
        check($sformatf("lat5 rsp%0d b2b ren", nrvd), 32'(o_ren), 32'h1);
        check($sformatf("lat5 rsp%0d next addr", nrvd), o_addr, rvd_addr + 32'd4);
        nrvd++;
      end
    end
    check("lat5 responses seen", 32'(nrvd), 32'd3);
    i_rvd = 1'b0;

    // Redirect while IDLE on the reset-release edge: no issue, then issue at target.
    do_reset();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h701;
    @(posedge clk); #1;
    i_redirect = 1'b0;
    check("idle redir ren", 32'(o_ren), 32'h0);
    check("idle redir addr hold", o_addr, 32'h100);
    @(posedge clk); #1;
    check("idle redir issue ren", 32'(o_ren), 32'h1);
    check("idle redir issue addr", o_addr, 32'h700);
    check("idle redir valid", 32'(o_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
